// File: rtl/sap1_control_unit_if.sv
// sap1_control_unit_if: opcode/mode/step inputs plus control lines and status of the SAP-1 sequencer
interface sap1_control_unit_if;
    logic [3:0] ir_opcode;
    logic       run_mode;
    logic       step;
    logic       Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Jp;
    logic [5:0] t_state;
    logic       busy, halted, illegal_op, instr_done;
    modport master (
        input  ir_opcode, run_mode, step,
        output Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Jp,
        output t_state, busy, halted, illegal_op, instr_done
    );
    modport slave (
        output ir_opcode, run_mode, step,
        input  Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Jp,
        input  t_state, busy, halted, illegal_op, instr_done
    );
endinterface

// File: rtl/sap1_control_unit.sv
// sap1_control_unit: SAP-1 T1..T6 sequencer with run/single-step, HALT and sticky illegal-opcode flag.
// Defining SAP1_JMP_EN turns opcode 0011 into JMP; otherwise it is an illegal NOP.
module sap1_control_unit (
    input  logic clk,
    input  logic reset,
    sap1_control_unit_if.master bus
);
    typedef enum logic [2:0] {T1, T2, T3, T4, T5, T6, WAIT, HALT} state_t;
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
    state_t state, cur;
    logic step_q, ill_q, step_edge, op_legal;
    // Reset overrides the visible state so outputs show T1 for the whole reset cycle.
    assign cur = reset ? T1 : state;
    assign step_edge = bus.step & ~step_q;
`ifdef SAP1_JMP_EN
    assign op_legal = bus.ir_opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_OUT, OP_HLT};
`else
    assign op_legal = bus.ir_opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT};
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= T1;
            step_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            step_q <= bus.step;
            if (state == T4 && !op_legal) ill_q <= 1'b1;
            case (state)
                T4:      state <= (bus.ir_opcode == OP_HLT) ? HALT : T5;
                T6:      state <= bus.run_mode ? T1 : WAIT;
                WAIT:    state <= (bus.run_mode || step_edge) ? T1 : WAIT;
                HALT:    state <= HALT;
                default: state <= state_t'(state + 3'd1);
            endcase
        end
    end
    always_comb begin
        {bus.Cp, bus.Ep, bus.Lm, bus.Ce, bus.Li, bus.Ei, bus.La} = '0;
        {bus.Ea, bus.Su, bus.Eu, bus.Lb, bus.Lo, bus.Jp} = '0;
        case (cur)
            T1: {bus.Ep, bus.Lm} = 2'b11;
            T2: bus.Cp = 1'b1;
            T3: {bus.Ce, bus.Li} = 2'b11;
            T4: case (bus.ir_opcode)
                OP_LDA, OP_ADD, OP_SUB: {bus.Ei, bus.Lm} = 2'b11;
                OP_OUT: {bus.Ea, bus.Lo} = 2'b11;
`ifdef SAP1_JMP_EN
                OP_JMP: {bus.Ei, bus.Jp} = 2'b11;
`endif
                default: ;
            endcase
            T5: case (bus.ir_opcode)
                OP_LDA: {bus.Ce, bus.La} = 2'b11;
                OP_ADD, OP_SUB: {bus.Ce, bus.Lb} = 2'b11;
                default: ;
            endcase
            T6: if (bus.ir_opcode == OP_ADD || bus.ir_opcode == OP_SUB) begin
                {bus.Eu, bus.La} = 2'b11;
                bus.Su = bus.ir_opcode == OP_SUB;
            end
            default: ;
        endcase
    end
    assign bus.t_state    = (cur == WAIT || cur == HALT) ? 6'd0 : 6'd1 << cur;
    assign bus.busy       = cur != WAIT && cur != HALT;
    assign bus.halted     = cur == HALT;
    assign bus.instr_done = cur == T6;
    assign bus.illegal_op = ~reset & (ill_q | (state == T4 & ~op_legal));
endmodule

// File: tb/tb_sap1_control_unit.sv
// tb_sap1_control_unit: vector table, corner-case sequences and random run against a microcode-table model
module tb_sap1_control_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    sap1_control_unit_if bus();
    sap1_control_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    localparam logic [12:0] CP = 13'h1000, EP = 13'h0800, LM = 13'h0400, CE = 13'h0200;
    localparam logic [12:0] LI = 13'h0100, EI = 13'h0080, LA = 13'h0040, EA = 13'h0020;
    localparam logic [12:0] SU = 13'h0010, EU = 13'h0008, LB = 13'h0004, LO = 13'h0002;
    localparam logic [12:0] JP = 13'h0001, NONE = 13'h0000;
    localparam logic [5:0] T1V = 6'b000001, T2V = 6'b000010, T3V = 6'b000100;
    localparam logic [5:0] T4V = 6'b001000, T5V = 6'b010000, T6V = 6'b100000;

    int errors = 0, checks = 0;
    int ph = 1;
    bit m_stepq = 0, m_ill = 0;
    logic [12:0] a_ctl;
    logic [9:0] a_st;

    typedef struct {
        logic r, run, stp;
        logic [3:0] op;
        logic [5:0] t;
        logic [12:0] ctl;
        logic ill;
    } vec_t;
    vec_t tab[$];

    function automatic bit legal(logic [3:0] op);
`ifdef SAP1_JMP_EN
        return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd14, 4'd15};
`else
        return op inside {4'd0, 4'd1, 4'd2, 4'd14, 4'd15};
`endif
    endfunction

    // Microcode per instruction: control words for T4, T5, T6.
    function automatic logic [12:0] micro(int p, logic [3:0] op);
        logic [12:0] ex [3];
        if (p == 1) return EP | LM;
        if (p == 2) return CP;
        if (p == 3) return CE | LI;
        if (p > 6) return NONE;
        ex = '{NONE, NONE, NONE};
        case (op)
            4'd0:  ex = '{EI | LM, CE | LA, NONE};
            4'd1:  ex = '{EI | LM, CE | LB, EU | LA};
            4'd2:  ex = '{EI | LM, CE | LB, EU | LA | SU};
            4'd14: ex = '{EA | LO, NONE, NONE};
`ifdef SAP1_JMP_EN
            4'd3:  ex = '{EI | JP, NONE, NONE};
`endif
            default: ;
        endcase
        return ex[p - 4];
    endfunction

    function automatic logic [12:0] act_ctl();
        return {bus.Cp, bus.Ep, bus.Lm, bus.Ce, bus.Li, bus.Ei, bus.La,
                bus.Ea, bus.Su, bus.Eu, bus.Lb, bus.Lo, bus.Jp};
    endfunction

    function automatic logic [9:0] act_st();
        return {bus.t_state, bus.busy, bus.halted, bus.illegal_op, bus.instr_done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rm, input logic st, input logic [3:0] op);
        reset = r;
        bus.run_mode = rm;
        bus.step = st;
        bus.ir_opcode = op;
        @(negedge clk);
        a_ctl = act_ctl();
        a_st = act_st();
    endtask

    task automatic model_check();
        int pe;
        logic [5:0] t;
        logic ill;
        pe = reset ? 1 : ph;
        t = (pe <= 6) ? 6'(1 << (pe - 1)) : 6'd0;
        ill = !reset && (m_ill || (ph == 4 && !legal(bus.ir_opcode)));
        chk("model ctl", 32'(a_ctl), 32'(micro(pe, bus.ir_opcode)));
        chk("model status", 32'(a_st), 32'({t, pe <= 6, pe == 8, ill, pe == 6}));
    endtask

    task automatic advance();
        if (reset) begin
            ph = 1;
            m_stepq = 0;
            m_ill = 0;
        end else begin
            if (ph == 4 && !legal(bus.ir_opcode)) m_ill = 1;
            case (ph)
                4: ph = (bus.ir_opcode == 4'd15) ? 8 : 5;
                6: ph = bus.run_mode ? 1 : 7;
                7: ph = (bus.run_mode || (bus.step && !m_stepq)) ? 1 : 7;
                8: ;
                default: ph++;
            endcase
            m_stepq = bus.step;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic rm, input logic st, input logic [3:0] op);
        drive(r, rm, st, op);
        model_check();
        advance();
    endtask

    initial begin
        int busy_n, done_n, halt_n, k;
        tab.push_back('{1, 1, 0, 4'd0,  T1V, EP | LM, 0});
        tab.push_back('{0, 1, 0, 4'd0,  T1V, EP | LM, 0});
        tab.push_back('{0, 1, 0, 4'd0,  T2V, CP, 0});
        tab.push_back('{0, 1, 0, 4'd0,  T3V, CE | LI, 0});
        tab.push_back('{0, 1, 0, 4'd0,  T4V, EI | LM, 0});
        tab.push_back('{0, 1, 0, 4'd0,  T5V, CE | LA, 0});
        tab.push_back('{0, 1, 0, 4'd0,  T6V, NONE, 0});
        tab.push_back('{0, 1, 0, 4'd2,  T1V, EP | LM, 0});
        tab.push_back('{0, 1, 0, 4'd2,  T2V, CP, 0});
        tab.push_back('{0, 1, 0, 4'd2,  T3V, CE | LI, 0});
        tab.push_back('{0, 1, 0, 4'd2,  T4V, EI | LM, 0});
        tab.push_back('{0, 1, 0, 4'd2,  T5V, CE | LB, 0});
        tab.push_back('{0, 1, 0, 4'd2,  T6V, EU | LA | SU, 0});
        tab.push_back('{0, 1, 0, 4'd5,  T1V, EP | LM, 0});
        tab.push_back('{0, 1, 0, 4'd5,  T2V, CP, 0});
        tab.push_back('{0, 1, 0, 4'd5,  T3V, CE | LI, 0});
        tab.push_back('{0, 1, 0, 4'd5,  T4V, NONE, 1});
        tab.push_back('{0, 1, 0, 4'd5,  T5V, NONE, 1});
        tab.push_back('{0, 1, 0, 4'd5,  T6V, NONE, 1});
        tab.push_back('{0, 1, 0, 4'd0,  T1V, EP | LM, 1});
        tab.push_back('{0, 1, 0, 4'd0,  T2V, CP, 1});
        tab.push_back('{0, 1, 0, 4'd0,  T3V, CE | LI, 1});
        tab.push_back('{0, 1, 0, 4'd0,  T4V, EI | LM, 1});
        tab.push_back('{1, 1, 0, 4'd0,  T1V, EP | LM, 0});
        tab.push_back('{0, 1, 0, 4'd14, T1V, EP | LM, 0});
        tab.push_back('{0, 1, 0, 4'd14, T2V, CP, 0});
        tab.push_back('{0, 1, 0, 4'd14, T3V, CE | LI, 0});
        tab.push_back('{0, 1, 0, 4'd14, T4V, EA | LO, 0});
        tab.push_back('{0, 1, 0, 4'd14, T5V, NONE, 0});
        tab.push_back('{0, 1, 0, 4'd14, T6V, NONE, 0});
        tab.push_back('{0, 1, 0, 4'd14, T1V, EP | LM, 0});
        foreach (tab[i]) begin
            drive(tab[i].r, tab[i].run, tab[i].stp, tab[i].op);
            chk($sformatf("vec%0d ctl", i), 32'(a_ctl), 32'(tab[i].ctl));
            chk($sformatf("vec%0d status", i), 32'(a_st),
                32'({tab[i].t, tab[i].t != 6'd0, 1'b0, tab[i].ill, tab[i].t == T6V}));
            advance();
        end

        // Single-step: reach WAIT, then a 10-cycle step pulse releases one instruction.
        k = 0;
        while (ph != 7 && k < 12) begin
            cyc(0, 0, 0, 4'd1);
            k++;
        end
        drive(0, 0, 0, 4'd1);
        chk("reach wait", 32'(a_st[9:4]), 32'(6'd0));
        model_check();
        advance();
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 18; i++) begin
            drive(0, 0, i < 10, 4'd1);
            busy_n += int'(a_st[3]);
            done_n += int'(a_st[0]);
            model_check();
            advance();
        end
        chk("step busy cycles", 32'(busy_n), 32'd6);
        chk("step done pulses", 32'(done_n), 32'd1);
        drive(0, 0, 0, 4'd1);
        chk("step back to wait", 32'(a_st[9:3]), 32'(7'd0));
        advance();

        // Halt: T4 idle, then HALT ignores step and run_mode until reset.
        cyc(1, 1, 0, 4'd15);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd15);
        drive(0, 1, 0, 4'd15);
        chk("hlt t4 ctl", 32'(a_ctl), 32'(NONE));
        chk("hlt t4 t_state", 32'(a_st[9:4]), 32'(T4V));
        advance();
        halt_n = 0;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'(i / 2), 1'(i), 4'(i));
            halt_n += int'(a_st[2] && !a_st[3] && a_ctl == NONE);
            model_check();
            advance();
        end
        chk("halted cycles", 32'(halt_n), 32'd20);
        cyc(1, 0, 0, 4'd0);
        drive(0, 0, 0, 4'd0);
        chk("after halt ctl", 32'(a_ctl), 32'(EP | LM));
        chk("after halt status", 32'(a_st), 32'({T1V, 1'b1, 1'b0, 1'b0, 1'b0}));
        advance();

        // Opcode 0011: JMP when enabled, illegal NOP otherwise.
        cyc(1, 1, 0, 4'd3);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'd3);
        drive(0, 1, 0, 4'd3);
`ifdef SAP1_JMP_EN
        chk("jmp t4 ctl", 32'(a_ctl), 32'(EI | JP));
        chk("jmp illegal", 32'(a_st[1]), 32'd0);
`else
        chk("op3 t4 ctl", 32'(a_ctl), 32'(NONE));
        chk("op3 illegal", 32'(a_st[1]), 32'd1);
`endif
        advance();

        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
                4'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sap1_control_unit.md
SAP1_CONTROL_UNIT -- requirements
Module: sap1_control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port ir_opcode, input, 4 bits: upper nibble of the instruction register; valid from T4 onward.
REQ-004 SHALL have port run_mode, input, 1 bit: 1 = continuous execution, 0 = single-step.
REQ-005 SHALL have port step, input, 1 bit: single-step request, rising-edge sensitive.
REQ-006 SHALL have ports Cp, Ep, Lm, Ce, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Jp, outputs, 1 bit each: datapath control lines, active-high.
REQ-007 SHALL have port t_state, output, 6 bits: one-hot ring count, T1=000001 through T6=100000; 000000 in WAIT/HALT.
REQ-008 SHALL have ports busy, halted, illegal_op and instr_done, outputs, 1 bit each.

Function
REQ-009 States SHALL be T1..T6, WAIT and HALT, held in a registered state machine.
REQ-010 Control lines SHALL be combinational from the current state and ir_opcode; no more than one bus driver (Ep, Ce, Ei, Ea, Eu) SHALL be high in any state.
REQ-011 Fetch SHALL assert T1: Ep, Lm; T2: Cp; T3: Ce, Li, for every opcode.
REQ-012 LDA (0000) SHALL assert T4: Ei, Lm; T5: Ce, La; T6: none.
REQ-013 ADD (0001) SHALL assert T4: Ei, Lm; T5: Ce, Lb; T6: Eu, La.
REQ-014 SUB (0010) SHALL match ADD, with Su also high in T6.
REQ-015 OUT (1110) SHALL assert T4: Ea, Lo; T5 and T6: none.
REQ-016 HLT (1111) SHALL assert no control line in T4, and the next edge SHALL enter HALT.
REQ-017 HALT SHALL hold all control lines low with halted=1 until reset; step and run_mode SHALL be ignored.
REQ-018 Other opcodes SHALL execute as NOP (T4-T6 idle) and SHALL set sticky illegal_op; illegal_op SHALL clear only on reset.
REQ-019 T1 through T5 SHALL each advance to the next T-state after exactly one cycle.
REQ-020 From T6, the next state SHALL be T1 if run_mode=1, otherwise WAIT.
REQ-021 instr_done SHALL be a one-cycle pulse during every T6.
REQ-022 WAIT SHALL drive all control lines low and SHALL go to T1 on the cycle after a detected step rising edge (step=1 while registered step=0).
REQ-023 A step held high SHALL release exactly one instruction; step edges during T1-T6 SHALL be ignored, not queued.
REQ-024 If run_mode=1 while in WAIT, the unit SHALL go to T1 on the next edge.
REQ-025 busy SHALL be 1 in T1-T6 and 0 in WAIT and HALT.
REQ-026 run_mode changes during T1-T6 SHALL take effect only at the T6 decision.

Reset
REQ-027 reset=1 at a rising edge SHALL force state T1, clear illegal_op and clear the step edge register; reset SHALL take priority over all other events, including mid-instruction and in HALT.
REQ-028 During and after the reset cycle, outputs SHALL reflect T1: Ep=1, Lm=1, t_state=000001, busy=1, all other controls 0, halted=0.

Configuration
REQ-029 With macro SAP1_JMP_EN defined, opcode 0011 SHALL be JMP, asserting T4: Ei, Jp; T5 and T6: none.
REQ-030 With SAP1_JMP_EN undefined, Jp SHALL be tied 0 and opcode 0011 SHALL be treated as illegal per REQ-018.

Verification
REQ-031 Reset, run_mode=1, opcode 0000 -> t_state 000001,000010,...,100000,000001 on consecutive cycles; Ce,La high only in T5.
REQ-032 Opcode 0010 in run mode -> T6 shows Eu=La=Su=1; instr_done pulses exactly once per 6 cycles.
REQ-033 run_mode=0 -> WAIT after T6; step held high for 10 cycles -> exactly one instruction (6 busy cycles), then WAIT.
REQ-034 Opcode 1111 -> T4 all controls 0, then halted=1 and busy=0 for 20 cycles under step pulses; reset -> T1 with Ep=Lm=1.
REQ-035 Opcode 0101 -> NOP with illegal_op=1 from T4 onward, persisting; reset asserted in T5 -> next state T1 and illegal_op=0.
REQ-036 Opcode 0011 -> with SAP1_JMP_EN: T4 Ei=Jp=1 and illegal_op=0; without it: Jp=0 and illegal_op=1.
